// File: rtl/slow_tick_gen.sv
// slow_tick_gen -- slow-rate timing source for the 2-bit slow counter.
//
// Divides the board clock into a square wave `cnt` and a matching one-cycle
// enable `tick` (high in the cycle `cnt` rises). The rate is selectable and
// the generator can free-run or be single-stepped from a debounced button.
//
// Parameters
//   BASE_DIV  : half-period in clk cycles at div_sel=0 (>= 64 for four rates)
//   DB_CYCLES : cycles `step` must hold a new level before it is accepted
//
// Ports
//   clk     in   system clock
//   clr     in   synchronous active-high reset
//   run     in   1 = free-run, 0 = stop/step mode (asynchronous switch)
//   step    in   single-step pushbutton (asynchronous, bouncy)
//   div_sel in   rate select, half-period N = BASE_DIV >> (2*div_sel)
//   cnt     out  divided square wave, registered
//   tick    out  one-cycle pulse in the cycle cnt goes 0->1
//   ticks   out  16-bit wrapping count of ticks (only with the macro below)
//
// Optional build: define SLOW_TICK_GEN_TICK_COUNT_EN to add the `ticks`
// output and its counter. Without it the block has no tick counter.

module slow_tick_gen #(
  parameter int BASE_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       step,
  input  logic [1:0] div_sel,
  output logic       cnt,
  output logic       tick
`ifdef SLOW_TICK_GEN_TICK_COUNT_EN
  ,
  output logic [15:0] ticks
`endif
);

  localparam int CNT_W = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
  localparam int DB_W  = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    S_STOP    = 2'd0,
    S_RUN     = 2'd1,
    S_STEP_HI = 2'd2
  } state_t;

  // Terminal count (N-1) for a rate select. A shift that would give N=0
  // (only possible with an undersized BASE_DIV) is clamped to N=1.
  function automatic logic [CNT_W-1:0] half_period_m1(input logic [1:0] sel);
    int n;
    n = BASE_DIV >> {sel, 1'b0};
    if (n < 1) n = 1;
    return CNT_W'(n - 1);
  endfunction

  logic             run_meta;
  logic             run_sync;
  logic             step_meta;
  logic             step_sync;
  logic             step_db;
  logic [DB_W-1:0]  db_cnt;
  logic             db_done;
  logic             step_edge;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] n_m1;
  logic             boundary;
  logic             tick_set;

  // ---- input synchronizers
  always_ff @(posedge clk) begin
    if (clr) begin
      run_meta  <= 1'b0;
      run_sync  <= 1'b0;
      step_meta <= 1'b0;
      step_sync <= 1'b0;
    end else begin
      run_meta  <= run;
      run_sync  <= run_meta;
      step_meta <= step;
      step_sync <= step_meta;
    end
  end

  // ---- step debounce
  // The count only advances while the synchronized level disagrees with the
  // accepted level; any agreement restarts it.
  assign db_done = (db_cnt == DB_W'(DB_CYCLES - 1));

  // Asserted in the cycle the debounced level is about to load 1, so the
  // FSM reacts on the same edge the debounced value rises.
  assign step_edge = step_sync & ~step_db & db_done;

  always_ff @(posedge clk) begin
    if (clr) begin
      step_db <= 1'b0;
      db_cnt  <= '0;
    end else if (step_sync != step_db) begin
      if (db_done) begin
        step_db <= step_sync;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // ---- divider / state machine
  assign boundary = (div_cnt == n_m1);

  // tick is only ever raised together with a 0->1 of cnt: either a step
  // launch from STOP or a rising phase boundary while running.
  always_comb begin
    tick_set = 1'b0;
    case (state)
      S_STOP:  tick_set = ~run_sync & step_edge;
      S_RUN:   tick_set = run_sync & ~cnt & boundary;
      default: tick_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_STOP;
      div_cnt <= '0;
      cnt     <= 1'b0;
      tick    <= 1'b0;
      n_m1    <= half_period_m1(div_sel);
    end else begin
      tick <= tick_set;
      case (state)
        S_STOP: begin
          div_cnt <= '0;
          cnt     <= 1'b0;
          // run has priority; a simultaneous step_edge is simply dropped
          if (run_sync) begin
            state <= S_RUN;
            n_m1  <= half_period_m1(div_sel);
          end else if (step_edge) begin
            state <= S_STEP_HI;
            cnt   <= 1'b1;
            n_m1  <= half_period_m1(div_sel);
          end
        end

        S_RUN: begin
          if (!run_sync && !cnt) begin
            state   <= S_STOP;
            div_cnt <= '0;
          end else begin
            div_cnt <= boundary ? '0 : div_cnt + 1'b1;
            if (boundary) begin
              cnt  <= ~cnt;
              n_m1 <= half_period_m1(div_sel);
              // only reachable with cnt=1: the high phase ends as run drops
              if (!run_sync) state <= S_STOP;
            end else if (!run_sync) begin
              // let the current high phase finish instead of cutting it short
              state <= S_STEP_HI;
            end
          end
        end

        S_STEP_HI: begin
          div_cnt <= boundary ? '0 : div_cnt + 1'b1;
          if (boundary) begin
            cnt   <= 1'b0;
            n_m1  <= half_period_m1(div_sel);
            state <= run_sync ? S_RUN : S_STOP;
          end
        end

        default: begin
          state   <= S_STOP;
          div_cnt <= '0;
          cnt     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SLOW_TICK_GEN_TICK_COUNT_EN
  // ---- tick counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (clr) begin
      ticks <= '0;
    end else if (tick_set) begin
      ticks <= ticks + 1'b1;
    end
  end
`endif

endmodule

// File: doc/slow_tick_gen.md
Name: slow_tick_gen

Overview:
- Upstream timing stage for the 2-bit slow counter; replaces the fixed slow-clock divider.
- Produces a divided square wave `cnt` and a one-cycle `tick` enable, both derived from the board clock.
- Supports run/stop control, a debounced single-step button, and four selectable rates.
- The downstream counter advances once per `cnt` rising edge (equivalently, once per `tick`).

Parameters:
- BASE_DIV, 50_000_000: half-period in clk cycles at div_sel=0 (1 Hz at 100 MHz). Must be ≥ 64.
- DB_CYCLES, 1_000_000: cycles `step` must be stable before its debounced value changes (10 ms).

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- run  in  1  1 = free-run, 0 = stop/step mode (async switch)
- step  in  1  single-step pushbutton (async, bouncy)
- div_sel  in  2  rate select: half-period N = BASE_DIV >> (2*div_sel), giving 1/4/16/64 Hz
- cnt  out  1  divided square wave, registered
- tick  out  1  one-cycle pulse, asserted in the cycle cnt goes 0→1

Behaviour:
- Interface: one clock, `clk`; reset `clr` is synchronous and active-high. All state updates on clk posedge.
- Reset (clr=1, has priority over every other event):
  - state=STOP, divider counter=0, cnt=0, tick=0.
  - Synchronizers, debounce counter and debounced step are cleared to 0.
  - Latched N reloads from div_sel.
- Input conditioning:
  - run and step each pass through a 2-FF synchronizer.
  - step debounce: the debounced value takes the synchronized value only after DB_CYCLES consecutive cycles differing from the current debounced value; any return resets the count.
  - step_edge = one-cycle pulse on a 0→1 of the debounced value. Total press-to-edge latency = 2 + DB_CYCLES cycles.
- Divider:
  - Counter width is $clog2(BASE_DIV).
  - Counts 0..N-1. On reaching N-1 it wraps to 0 and a phase boundary occurs.
  - N is latched from div_sel only at a phase boundary or on STOP exit. A mid-phase div_sel change never shortens or lengthens the current phase.
- States:
  - STOP: counter held at 0, cnt=0.
    - sync run=1 → RUN.
    - Else step_edge → STEP_HI, with cnt=1 and tick=1 in the same cycle.
    - If both occur in one cycle, run wins and step_edge is dropped.
  - RUN: cnt toggles at each phase boundary; tick=1 on each 0→1 toggle.
    - sync run=0 while cnt=0 → STOP, counter cleared.
    - sync run=0 while cnt=1 → STEP_HI, counter kept, so the high phase completes and no runt pulse is produced.
  - STEP_HI: counter runs. At the phase boundary cnt→0, then → RUN if sync run=1, else → STOP.
    - step_edge in this state is ignored (not queued).
- Output timing:
  - tick is never asserted unless cnt transitions 0→1 in that same cycle.
  - In RUN, cnt period = 2N cycles with 50% duty cycle.
  - First RUN rise occurs N cycles after entering RUN.
- Reset mid-phase: cnt drops to 0 the cycle after clr is sampled; no tick is generated by reset.

Optional Feature:
- Macro: SLOW_TICK_GEN_TICK_COUNT_EN.
- When defined:
  - Adds output `ticks` [15:0], incremented on every tick (both RUN and step).
  - Wraps 0xFFFF→0x0000; cleared by clr.
  - Also counted when a clr and a tick cannot coincide (clr has priority).
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (BASE_DIV=8, DB_CYCLES=4):
- clr=1 for 2 cycles with run=1, step bouncing → cnt=0, tick=0, state STOP throughout; after release, first cnt rise 2+8 cycles later.
- run=1, div_sel=0 → cnt high 8 / low 8 cycles; tick width 1 cycle, coincident with each rise; 4 ticks in 64 cycles. div_sel=1 → 2/2 cycles after the next boundary.
- run=0, step pulsed 1-0-1-0-1 (1-cycle bounces) then held high 10 cycles → exactly one tick, at 2+4 cycles after the stable high begins; cnt high for 8 cycles, then 0 and held.
- run falls while cnt=1 at counter=3 → cnt stays high 4 more cycles, then 0, then STOP; run falls while cnt=0 → immediate STOP, no tick.
- In STOP, run rise and step_edge in the same cycle → RUN entered, no tick that cycle, first tick after N=8 cycles. With the macro, ticks=0xFFFF → next tick gives 0x0000.
